// File: rtl/mdc_copr_pkg.sv
// Shared types and constants for the memory-mapped multiply coprocessor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdc_copr_pkg;

    // Engine sequencing: one element takes RD -> WAIT -> WP -> WA.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WP   = 3'd3,
        WA   = 3'd4,
        DONE = 3'd5
    } state_t;

    // Only kernel ID 1 launches the multiply engine.
    localparam int KERNEL_MUL = 1;

    // Config word layout: {.., burst, size, base}, base at bit 0.
    localparam int CONF_BASE_LSB = 0;

    function automatic int conf_size_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int conf_burst_lsb(input int addr_w, input int count_w);
        return addr_w + count_w;
    endfunction

endpackage

// File: rtl/mdc_copr_mem.sv
// Local data memory: one shared write port (engine beats host) and three registered read ports.
// Latency: writes land at the clock edge; every read port returns data one cycle after its enable.
// Backpressure: none; a host write colliding with an engine write is dropped.
module mdc_copr_mem #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_waddr,
    input  logic [DW-1:0] i_host_wdat,
    input  logic          i_eng_we,
    input  logic [AW-1:0] i_eng_waddr,
    input  logic [DW-1:0] i_eng_wdat,
    input  logic          i_host_re,
    input  logic [AW-1:0] i_host_raddr,
    output logic [DW-1:0] o_host_rdat,
    input  logic          i_eng_re,
    input  logic [AW-1:0] i_eng_raddr_a,
    input  logic [AW-1:0] i_eng_raddr_b,
    output logic [DW-1:0] o_eng_rdat_a,
    output logic [DW-1:0] o_eng_rdat_b
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdat;

    assign w_we    = i_eng_we | i_host_we;
    assign w_waddr = i_eng_we ? i_eng_waddr : i_host_waddr;
    assign w_wdat  = i_eng_we ? i_eng_wdat  : i_host_wdat;

    // Storage array, deliberately not reset so contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdat;
        end
    end

    // Host read register holds its value while the host is not reading.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_host_rdat <= '0;
        end else if (i_host_re) begin
            o_host_rdat <= r_mem[i_host_raddr];
        end
    end

    // Operand A/B fetch registers for the engine.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_eng_rdat_a <= '0;
            o_eng_rdat_b <= '0;
        end else if (i_eng_re) begin
            o_eng_rdat_a <= r_mem[i_eng_raddr_a];
            o_eng_rdat_b <= r_mem[i_eng_raddr_b];
        end
    end

endmodule

// File: rtl/mdc_mm_coprocessor.sv
// Multiply coprocessor: p[i]=A[i]*B[i] and running sum written back to local memory (COPROCESSOR_FINISH_EN adds finish).
// Latency: host read 1 cycle; a kernel run of N elements takes 4N+1 cycles after the start strobe.
// Backpressure: none; config loads and kernel starts are ignored while busy, host writes lose to engine writes.
module mdc_mm_coprocessor
    import mdc_copr_pkg::*;
#(
    parameter int SIZEID      = 8,
    parameter int SIZEADDRESS = 12,
    parameter int SIZECOUNT   = 12,
    parameter int SIZEPORT    = 2,
    parameter int SIZEDATA    = 32,
    parameter int SIZEBURST   = 8,
    parameter int SIZESIGNAL  = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZEDATA-1:0]    datain,
    input  logic [SIZEADDRESS-1:0] addressrd,
    input  logic [SIZEADDRESS-1:0] addresswr,
    input  logic                   enablerd,
    input  logic                   enablewr,
    input  logic                   write,
    input  logic [SIZEID-1:0]      kernelIDin,
    input  logic                   kernelIDen,
    output logic [SIZEID-1:0]      kernelIDout,
    input  logic [SIZEDATA-1:0]    confin_0,
    input  logic [SIZEDATA-1:0]    confin_1,
    input  logic [SIZEDATA-1:0]    confin_2,
    input  logic [SIZEDATA-1:0]    confin_3,
    input  logic                   en_0,
    input  logic                   en_1,
    input  logic                   en_2,
    input  logic                   en_3,
`ifdef COPROCESSOR_FINISH_EN
    output logic                   finish,
`endif
    output logic [SIZEDATA-1:0]    dataout
);

    localparam int SIZE_LSB  = conf_size_lsb(SIZEADDRESS);
    localparam int BURST_LSB = conf_burst_lsb(SIZEADDRESS, SIZECOUNT);
    localparam int OFFW      = SIZECOUNT + SIZEBURST;
    localparam int NPORT     = 1 << SIZEPORT;
    // Prefetch depth and signal width have no effect on this datapath.
    localparam int p_unused_params = FIFO_DEPTH + SIZESIGNAL;

    state_t                 r_state, w_next;
    logic [SIZEDATA-1:0]    r_conf [0:NPORT-1];
    logic [SIZEID-1:0]      r_kid;
    logic [SIZECOUNT-1:0]   r_idx;
    logic [SIZEDATA-1:0]    r_acc;
    logic [SIZEDATA-1:0]    r_prod;

    logic [SIZEDATA-1:0]    w_conf_in [0:NPORT-1];
    logic [NPORT-1:0]       w_conf_en;
    logic [SIZEADDRESS-1:0] w_addr [0:NPORT-1];
    logic [SIZECOUNT-1:0]   w_n;
    logic [SIZECOUNT-1:0]   w_idx_inc;
    logic                   w_idle;
    logic                   w_eng_re;
    logic                   w_eng_we;
    logic [SIZEADDRESS-1:0] w_eng_waddr;
    logic [SIZEDATA-1:0]    w_eng_wdat;
    logic [SIZEDATA-1:0]    w_rd_a, w_rd_b, w_prod;
    logic                   w_unused_conf;

    assign w_conf_in[0] = confin_0;
    assign w_conf_in[1] = confin_1;
    assign w_conf_in[2] = confin_2;
    assign w_conf_in[3] = confin_3;
    assign w_conf_en    = {en_3, en_2, en_1, en_0};

    // Only the size of port 0 sets the element count; other size fields are just stored.
    assign w_n           = r_conf[0][SIZE_LSB +: SIZECOUNT];
    assign w_idx_inc     = r_idx + SIZECOUNT'(1);
    assign w_idle        = (r_state == IDLE);
    assign w_eng_re      = (r_state == RD);
    assign w_prod        = w_rd_a * w_rd_b;
    assign w_unused_conf = ^{r_conf[0], r_conf[1], r_conf[2], r_conf[3]};
    assign kernelIDout   = r_kid;
`ifdef COPROCESSOR_FINISH_EN
    assign finish        = (r_state == DONE);
`endif

    // Element address per port: base + i*stride, stride 0 behaves as 1, wraps in memory space.
    for (genvar k = 0; k < NPORT; k++) begin : g_addr
        logic [SIZEBURST-1:0] w_burst;
        logic [SIZEBURST-1:0] w_stride;
        assign w_burst   = r_conf[k][BURST_LSB +: SIZEBURST];
        assign w_stride  = (w_burst == '0) ? SIZEBURST'(1) : w_burst;
        assign w_addr[k] = r_conf[k][CONF_BASE_LSB +: SIZEADDRESS]
                         + SIZEADDRESS'(OFFW'(r_idx) * OFFW'(w_stride));
    end

    // Next-state logic of the element sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (kernelIDen && (kernelIDin == SIZEID'(KERNEL_MUL)) && (w_n != '0)) begin
                    w_next = RD;
                end
            end
            RD:      w_next = WAIT;
            WAIT:    w_next = WP;
            WP:      w_next = WA;
            WA:      w_next = (w_idx_inc == w_n) ? DONE : RD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Engine write port: product in WP, running sum in WA.
    always_comb begin
        w_eng_we    = 1'b0;
        w_eng_waddr = w_addr[2];
        w_eng_wdat  = r_prod;
        if (r_state == WP) begin
            w_eng_we = 1'b1;
        end else if (r_state == WA) begin
            w_eng_we    = 1'b1;
            w_eng_waddr = w_addr[3];
            w_eng_wdat  = r_acc;
        end
    end

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Config words and kernel ID are only writable while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NPORT; k++) begin
                r_conf[k] <= '0;
            end
            r_kid <= '0;
        end else if (w_idle) begin
            for (int k = 0; k < NPORT; k++) begin
                if (w_conf_en[k]) begin
                    r_conf[k] <= w_conf_in[k];
                end
            end
            if (kernelIDen) begin
                r_kid <= kernelIDin;
            end
        end
    end

    // Datapath: multiply/accumulate in WAIT, advance index in WA, clear at DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_prod <= '0;
        end else begin
            case (r_state)
                WAIT: begin
                    r_prod <= w_prod;
                    r_acc  <= r_acc + w_prod;
                end
                WA:   r_idx <= w_idx_inc;
                DONE: begin
                    r_idx <= '0;
                    r_acc <= '0;
                end
                default: ;
            endcase
        end
    end

    mdc_copr_mem #(
        .AW (SIZEADDRESS),
        .DW (SIZEDATA)
    ) u_mem (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_host_we     (enablewr & write),
        .i_host_waddr  (addresswr),
        .i_host_wdat   (datain),
        .i_eng_we      (w_eng_we),
        .i_eng_waddr   (w_eng_waddr),
        .i_eng_wdat    (w_eng_wdat),
        .i_host_re     (enablerd),
        .i_host_raddr  (addressrd),
        .o_host_rdat   (dataout),
        .i_eng_re      (w_eng_re),
        .i_eng_raddr_a (w_addr[0]),
        .i_eng_raddr_b (w_addr[1]),
        .o_eng_rdat_a  (w_rd_a),
        .o_eng_rdat_b  (w_rd_b)
    );

endmodule

// File: tb/tb_mdc_mm_coprocessor.sv
// Bench for the multiply coprocessor: host memory access, kernel runs, strides, overflow, mid-run events.
// Latency: expected host-read data is queued when the read is issued and compared one cycle later.
// Backpressure: n/a.
module tb_mdc_mm_coprocessor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] datain;
    logic [11:0] addressrd, addresswr;
    logic        enablerd, enablewr, write;
    logic [7:0]  kernelIDin;
    logic        kernelIDen;
    logic [7:0]  kernelIDout;
    logic [31:0] confin_0, confin_1, confin_2, confin_3;
    logic        en_0, en_1, en_2, en_3;
    logic [31:0] dataout;
`ifdef COPROCESSOR_FINISH_EN
    logic        finish;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [0:4095];
    logic [11:0] cfg_base  [0:3];
    logic [11:0] cfg_size  [0:3];
    logic [7:0]  cfg_burst [0:3];
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    mdc_mm_coprocessor dut (
        .clk         (clk),
        .rst         (rst),
        .datain      (datain),
        .addressrd   (addressrd),
        .addresswr   (addresswr),
        .enablerd    (enablerd),
        .enablewr    (enablewr),
        .write       (write),
        .kernelIDin  (kernelIDin),
        .kernelIDen  (kernelIDen),
        .kernelIDout (kernelIDout),
        .confin_0    (confin_0),
        .confin_1    (confin_1),
        .confin_2    (confin_2),
        .confin_3    (confin_3),
        .en_0        (en_0),
        .en_1        (en_1),
        .en_2        (en_2),
        .en_3        (en_3),
`ifdef COPROCESSOR_FINISH_EN
        .finish      (finish),
`endif
        .dataout     (dataout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [11:0] a, input logic [31:0] d);
        enablewr  = 1'b1;
        write     = 1'b1;
        addresswr = a;
        datain    = d;
        tick();
        enablewr  = 1'b0;
        write     = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic check_mem(input logic [11:0] a, input string name);
        logic [31:0] exp;
        sb_q.push_back(model_mem[a]);
        addressrd = a;
        enablerd  = 1'b1;
        tick();
        enablerd  = 1'b0;
        exp = sb_q.pop_front();
        checks++;
        if (dataout !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got=%h exp=%h", name, a, dataout, exp);
        end
    endtask

    task automatic check_kid(input logic [7:0] exp, input string name);
        checks++;
        if (kernelIDout !== exp) begin
            errors++;
            $display("FAIL %s kernelIDout got=%0d exp=%0d", name, kernelIDout, exp);
        end
    endtask

    task automatic configure(input int k, input logic [11:0] base, input logic [11:0] size,
                             input logic [7:0] burst);
        logic [31:0] w;
        w = {burst, size, base};
        case (k)
            0: begin confin_0 = w; en_0 = 1'b1; end
            1: begin confin_1 = w; en_1 = 1'b1; end
            2: begin confin_2 = w; en_2 = 1'b1; end
            default: begin confin_3 = w; en_3 = 1'b1; end
        endcase
        tick();
        en_0 = 1'b0; en_1 = 1'b0; en_2 = 1'b0; en_3 = 1'b0;
        cfg_base[k]  = base;
        cfg_size[k]  = size;
        cfg_burst[k] = burst;
    endtask

    function automatic logic [11:0] elem_addr(input int k, input int i);
        int s;
        s = (cfg_burst[k] == 8'd0) ? 1 : int'(cfg_burst[k]);
        return 12'((int'(cfg_base[k]) + i * s) % 4096);
    endfunction

    // Reference: first 'count' elements of the kernel, in element order.
    function automatic void model_kernel(input int count);
        logic [31:0] acc, p;
        acc = 32'd0;
        for (int i = 0; i < count; i++) begin
            p   = model_mem[elem_addr(0, i)] * model_mem[elem_addr(1, i)];
            acc = acc + p;
            model_mem[elem_addr(2, i)] = p;
            model_mem[elem_addr(3, i)] = acc;
        end
    endfunction

    // Start a kernel and step until the engine is back to idle, tracking finish.
    task automatic run_kernel(input logic [7:0] id, input string name);
        int n;
        bit running;
        int len;
        n       = int'(cfg_size[0]);
        running = (id == 8'd1) && (n != 0);
        len     = running ? 4 * n + 1 : 2;
        kernelIDin = id;
        kernelIDen = 1'b1;
        tick();
        kernelIDen = 1'b0;
        if (running) model_kernel(n);
        for (int j = 0; j <= len; j++) begin
`ifdef COPROCESSOR_FINISH_EN
            begin
                logic exp_f;
                exp_f = running && (j == 4 * n);
                checks++;
                if (finish !== exp_f) begin
                    errors++;
                    $display("FAIL %s finish cycle=%0d got=%b exp=%b", name, j, finish, exp_f);
                end
            end
`endif
            tick();
        end
        check_kid(id, name);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        datain = '0; addressrd = '0; addresswr = '0;
        enablerd = 1'b0; enablewr = 1'b0; write = 1'b0;
        kernelIDin = '0; kernelIDen = 1'b0;
        confin_0 = '0; confin_1 = '0; confin_2 = '0; confin_3 = '0;
        en_0 = 1'b0; en_1 = 1'b0; en_2 = 1'b0; en_3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_base[k] = '0; cfg_size[k] = '0; cfg_burst[k] = '0;
        end
        #12;
        checks++;
        if (dataout !== 32'd0) begin
            errors++;
            $display("FAIL reset dataout got=%h exp=0", dataout);
        end
        check_kid(8'd0, "reset");
`ifdef COPROCESSOR_FINISH_EN
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL reset finish got=%b exp=0", finish);
        end
`endif
        rst = 1'b1;
        tick();
    endtask

    task automatic test_host_rw();
        for (int i = 0; i < 4; i++) host_write(12'(i), 32'(i));
        for (int i = 0; i < 4; i++) check_mem(12'(i), "host_rw");
    endtask

    task automatic test_mul();
        for (int i = 0; i < 4; i++) host_write(12'(i), 32'(i + 1));
        for (int i = 0; i < 4; i++) host_write(12'(10 + i), 32'(i + 5));
        configure(0, 12'd0,  12'd4, 8'd1);
        configure(1, 12'd10, 12'd4, 8'd1);
        configure(2, 12'd20, 12'd4, 8'd1);
        configure(3, 12'd30, 12'd4, 8'd1);
        run_kernel(8'd1, "mul");
        for (int i = 0; i < 4; i++) check_mem(12'(20 + i), "mul_prod");
        for (int i = 0; i < 4; i++) check_mem(12'(30 + i), "mul_acc");
    endtask

    task automatic test_kernel2();
        for (int i = 0; i < 4; i++) host_write(12'(20 + i), 32'hBAD0_0000 + 32'(i));
        run_kernel(8'd2, "kernel2");
        for (int i = 0; i < 4; i++) check_mem(12'(20 + i), "kernel2_nowrite");
    endtask

    task automatic test_stride();
        for (int i = 0; i < 8; i++) host_write(12'(i), 32'(i + 1));
        configure(0, 12'd0,  12'd4, 8'd2);
        configure(2, 12'd40, 12'd4, 8'd1);
        configure(3, 12'd50, 12'd4, 8'd0);
        run_kernel(8'd1, "stride");
        for (int i = 0; i < 4; i++) check_mem(12'(40 + i), "stride_prod");
        for (int i = 0; i < 4; i++) check_mem(12'(50 + i), "stride_acc");
        // Zero-length job: latches the ID but writes nothing.
        for (int i = 0; i < 4; i++) host_write(12'(40 + i), 32'hDEAD_0000 + 32'(i));
        host_write(12'd50, 32'hDEAD_0050);
        configure(0, 12'd0, 12'd0, 8'd2);
        run_kernel(8'd3, "size0_pre");
        run_kernel(8'd1, "size0");
        for (int i = 0; i < 4; i++) check_mem(12'(40 + i), "size0_nowrite");
        check_mem(12'd50, "size0_nowrite_acc");
    endtask

    task automatic test_overflow();
        host_write(12'd100, 32'h0001_0000);
        host_write(12'd110, 32'h0001_0000);
        host_write(12'd101, 32'h0001_0001);
        host_write(12'd111, 32'h0001_0001);
        configure(0, 12'd100, 12'd2, 8'd1);
        configure(1, 12'd110, 12'd2, 8'd1);
        configure(2, 12'd120, 12'd2, 8'd1);
        configure(3, 12'd130, 12'd2, 8'd1);
        run_kernel(8'd1, "overflow");
        check_mem(12'd120, "ovf_prod0");
        check_mem(12'd121, "ovf_prod1");
        check_mem(12'd131, "ovf_acc1");
    endtask

    task automatic test_midrun();
        int n;
        configure(0, 12'd0,  12'd4, 8'd1);
        configure(1, 12'd10, 12'd4, 8'd1);
        configure(2, 12'd20, 12'd4, 8'd1);
        configure(3, 12'd30, 12'd4, 8'd1);
        for (int i = 0; i < 4; i++) host_write(12'(20 + i), 32'h5EED_0000);
        for (int i = 0; i < 4; i++) host_write(12'(30 + i), 32'h5EED_0001);
        for (int j = 0; j <= 16; j++) host_write(12'(200 + j), 32'd0);
        n = int'(cfg_size[0]);
        kernelIDin = 8'd1;
        kernelIDen = 1'b1;
        tick();
        kernelIDen = 1'b0;
        model_kernel(n);
        for (int j = 0; j <= 4 * n; j++) begin
            enablewr  = 1'b1;
            write     = 1'b1;
            addresswr = 12'(200 + j);
            datain    = 32'hA000 + 32'(j);
            if ((j % 4) < 2 || j == 4 * n) model_mem[12'(200 + j)] = 32'hA000 + 32'(j);
            if (j == 2) begin
                kernelIDin = 8'd5;
                kernelIDen = 1'b1;
                confin_0   = {8'd1, 12'd1, 12'd0};
                en_0       = 1'b1;
            end
            tick();
            kernelIDen = 1'b0;
            en_0       = 1'b0;
        end
        enablewr = 1'b0;
        write    = 1'b0;
        check_kid(8'd1, "midrun_kid");
        for (int i = 0; i < 4; i++) check_mem(12'(20 + i), "midrun_prod");
        for (int i = 0; i < 4; i++) check_mem(12'(30 + i), "midrun_acc");
        for (int j = 0; j <= 16; j++) check_mem(12'(200 + j), "midrun_hostwr");
    endtask

    task automatic test_reset_midrun();
        configure(2, 12'd80, 12'd4, 8'd1);
        configure(3, 12'd90, 12'd4, 8'd1);
        host_write(12'd80, 32'hCAFE_0080);
        host_write(12'd81, 32'hCAFE_0081);
        host_write(12'd90, 32'hCAFE_0090);
        host_write(12'd91, 32'hCAFE_0091);
        check_mem(12'd81, "rstmid_pre");
        kernelIDin = 8'd1;
        kernelIDen = 1'b1;
        tick();
        kernelIDen = 1'b0;
        // Six cycles in, element 0 is complete and element 1 is about to write.
        model_kernel(1);
        for (int j = 0; j < 6; j++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (dataout !== 32'd0) begin
            errors++;
            $display("FAIL rstmid dataout got=%h exp=0", dataout);
        end
        check_kid(8'd0, "rstmid");
`ifdef COPROCESSOR_FINISH_EN
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL rstmid finish got=%b exp=0", finish);
        end
`endif
        #2;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_base[k] = '0; cfg_size[k] = '0; cfg_burst[k] = '0;
        end
        tick();
        tick();
        check_mem(12'd80, "rstmid_prod0");
        check_mem(12'd81, "rstmid_prod1_kept");
        check_mem(12'd90, "rstmid_acc0");
        check_mem(12'd91, "rstmid_acc1_kept");
        run_kernel(8'd1, "rstmid_idle_after");
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_mul();
        test_kernel2();
        test_stride();
        test_overflow();
        test_midrun();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdc_mm_coprocessor.md
Name: mdc_mm_coprocessor

Overview:
- Memory-mapped multiply coprocessor generated in the Multi-Dataflow Composer style.
- Holds a local data memory that the host writes and reads through dedicated ports.
- Has four per-port configuration registers (burst/size/base address).
- Writing a kernel ID starts a compute engine that streams operands from memory, multiplies them and writes results back.

Parameters:
SIZEID, 8, kernel ID width
SIZEADDRESS, 12, local memory address width (depth 2^SIZEADDRESS words)
SIZECOUNT, 12, size (element count) field width
SIZEPORT, 2, bits to index the 4 ports
SIZEDATA, 32, data word width
SIZEBURST, 8, burst (stride) field width
SIZESIGNAL, 1, control signal width
FIFO_DEPTH, 4, operand prefetch depth; accepted, no functional effect in this version

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
datain  in  SIZEDATA  host write data
addressrd  in  SIZEADDRESS  host read address
addresswr  in  SIZEADDRESS  host write address
enablerd  in  1  host read port enable
enablewr  in  1  host write port enable
write  in  1  host write strobe
kernelIDin  in  SIZEID  kernel to start
kernelIDen  in  1  kernel ID load/start strobe
kernelIDout  out  SIZEID  current/last kernel ID
confin_0..confin_3  in  SIZEDATA each  port k config word
en_0..en_3  in  1 each  port k config load strobe
dataout  out  SIZEDATA  host read data

Behaviour:
- Reset (rst=0, async):
  - config regs, kernelIDout, engine state, counters, accumulator and dataout all clear to 0.
  - Memory contents are not cleared.
- Config word layout:
  - base = [SIZEADDRESS-1:0]
  - size = [SIZEADDRESS+SIZECOUNT-1:SIZEADDRESS]
  - burst = next SIZEBURST bits
  - Remaining upper bits are ignored.
  - en_k=1 latches confin_k at the clock edge; loads are allowed only in IDLE and are ignored while busy.
- Port roles:
  - port0 = operand A, port1 = operand B.
  - port2 = product output, port3 = running-sum output.
  - burst is the address stride per element; burst=0 is treated as 1.
  - Element count N = size of port0. The size fields of ports 1–3 are stored but unused.
- Host write: enablewr&write writes datain to mem[addresswr]. It is dropped if the engine writes in the same cycle (engine has priority).
- Host read: enablerd registers mem[addressrd] into dataout (1-cycle latency). dataout holds its value when enablerd=0. The read port is independent of the engine.
- Start:
  - kernelIDen in IDLE latches kernelIDin into kernelIDout in all cases.
  - If the ID is 1 and N>0, go to RD; otherwise stay IDLE.
  - kernelIDen while busy is ignored.
- Engine FSM (per element i):
  - IDLE
  - RD: issue internal reads of A at base0+i*stride0 and B at base1+i*stride1.
  - WAIT: data registered; compute p = A*B truncated to SIZEDATA bits; acc = acc+p, wrapping.
  - WP: write p to base2+i*stride2.
  - WA: write acc to base3+i*stride3; i++. If i==N go to DONE, else RD.
  - DONE: one cycle, clear i and acc, return to IDLE.
  - Run length is 4N+1 cycles after start.
- Address arithmetic wraps modulo 2^SIZEADDRESS.
- Reset mid-run aborts immediately to IDLE. Partial results remain in memory.

Optional Feature:
- Macro COPROCESSOR_FINISH_EN.
- Defined: adds output port finish (1 bit), high for exactly the DONE cycle, reset 0.
- Undefined: no finish port; behaviour otherwise identical.

Decomposition:
- Package mdc_copr_pkg holds:
  - the engine state enum (IDLE, RD, WAIT, WP, WA, DONE);
  - the kernel ID constant KERNEL_MUL=1;
  - field offset constants for the config word.
- One sub-module, mdc_copr_mem: 1 write port and 3 registered read ports (host, A, B) with the write-priority mux.

Test Plan:
- Reset, then host write mem[0..3]=0,1,2,3; read each address with enablerd → dataout=0,1,2,3 one cycle after the address.
- Write A=1,2,3,4 at 0..3 and B=5,6,7,8 at 10..13. Configure ports (burst 1, size 4, bases 0/10/20/30). Kernel 1 → after 17 cycles mem[20..23]=5,12,21,32 and mem[30..33]=5,17,38,70; kernelIDout=1.
- Kernel ID 2 with the same setup → kernelIDout=2, no memory change, engine stays IDLE.
- Stride: port0 burst 2 over A at 0,2,4,6 → products use every other word; size 0 → immediate IDLE, no writes.
- Overflow: A=B=0x10000 → product 0 (truncated).
- kernelIDen and en_k asserted mid-run are ignored; host write mid-run lands except in WP/WA cycles; assert rst mid-run → IDLE, outputs 0.
- With COPROCESSOR_FINISH_EN: finish pulses exactly one cycle, 4N+1 cycles after start.
